mode_rate_counter: RTL and testbench

Downstream consumer of the quick/slow mode FSM: takes its 1-bit mode output and produces a 2-digit BCD count (00–99) that advances at a mode-dependent rate. A programmable prescaler generates one-cycle ticks every QUICK_DIV cycles in quick mode and every SLOW_DIV cycles in slow mode; each tick increments the BCD pair. Outputs feed the seven-segment display driver.

---
 rtl/mode_rate_counter.sv | 105 ++++++++++
 tb/tb_mode_rate_counter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_rate_counter.sv
// Two-digit BCD counter that advances at a quick or slow rate picked by the mode FSM output.
// Define MODE_RATE_COUNTER_WRAP_EN to wrap 99->00 with a full pulse; otherwise it saturates at 99 and full latches.
module mode_rate_counter #(
    parameter int unsigned QUICK_DIV = 25_000_000,
    parameter int unsigned SLOW_DIV  = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       clear,
    output logic       tick,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0,
    output logic       full
);

    localparam logic [26:0] QUICK_LIMIT = 27'(QUICK_DIV - 1);
    localparam logic [26:0] SLOW_LIMIT  = 27'(SLOW_DIV - 1);

    logic [26:0] cnt;
    logic [26:0] limit;
    logic        mode_q;
    logic        mode_change;
    logic        tick_due;
    logic [3:0]  inc1;
    logic [3:0]  inc0;
    logic        full_next;

    always_comb begin
        limit       = mode ? SLOW_LIMIT : QUICK_LIMIT;
        mode_change = (mode != mode_q);
        tick_due    = (cnt == limit);
    end

    // Digit values and full level that a tick on this edge would produce.
    always_comb begin
        inc1      = bcd1;
        inc0      = bcd0;
        full_next = 1'b0;
`ifdef MODE_RATE_COUNTER_WRAP_EN
        if (bcd0 == 4'd9) begin
            inc0 = 4'd0;
            if (bcd1 == 4'd9) begin
                inc1      = 4'd0;
                full_next = 1'b1;
            end else begin
                inc1 = bcd1 + 4'd1;
            end
        end else begin
            inc0 = bcd0 + 4'd1;
        end
`else
        if (bcd1 == 4'd9 && bcd0 == 4'd9) begin
            inc1 = bcd1;
            inc0 = bcd0;
        end else if (bcd0 == 4'd9) begin
            inc0 = 4'd0;
            inc1 = bcd1 + 4'd1;
        end else begin
            inc0 = bcd0 + 4'd1;
        end
        full_next = full | ((inc1 == 4'd9) && (inc0 == 4'd9));
`endif
    end

    // A mode change restarts the prescaler so the new rate always counts a full period.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            mode_q <= 1'b1;
            tick   <= 1'b0;
            bcd1   <= 4'd0;
            bcd0   <= 4'd0;
            full   <= 1'b0;
        end else begin
            mode_q <= mode;
            if (clear) begin
                cnt  <= '0;
                tick <= 1'b0;
                bcd1 <= 4'd0;
                bcd0 <= 4'd0;
                full <= 1'b0;
            end else if (mode_change) begin
                cnt  <= '0;
                tick <= 1'b0;
`ifdef MODE_RATE_COUNTER_WRAP_EN
                full <= 1'b0;
`endif
            end else if (tick_due) begin
                cnt  <= '0;
                tick <= 1'b1;
                bcd1 <= inc1;
                bcd0 <= inc0;
                full <= full_next;
            end else begin
                cnt  <= cnt + 27'd1;
                tick <= 1'b0;
`ifdef MODE_RATE_COUNTER_WRAP_EN
                full <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mode_rate_counter.sv
// Scoreboard bench for mode_rate_counter with QUICK_DIV=4, SLOW_DIV=10.
// Expected {full,bcd1,bcd0} per tick are queued when stimulus starts and popped on each tick.
module tb_mode_rate_counter;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       mode  = 1'b1;
    logic       clear = 1'b0;
    logic       tick;
    logic [3:0] bcd1;
    logic [3:0] bcd0;
    logic       full;

    int checks = 0;
    int errors = 0;
    logic [8:0] expQ[$];

    mode_rate_counter #(
        .QUICK_DIV(4),
        .SLOW_DIV (10)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .mode (mode),
        .clear(clear),
        .tick (tick),
        .bcd1 (bcd1),
        .bcd0 (bcd0),
        .full (full)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Returns the number of edges until tick is seen, or -1 when the budget runs out.
    task automatic waitTick(input int maxEdges, output int edges);
        edges = -1;
        for (int i = 1; i <= maxEdges; i++) begin
            @(posedge clk);
            #1;
            if (tick === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        logic [8:0] exp;
        #2 rst = 1'b0;
        #10;
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
        @(posedge clk);
        #1 rst = 1'b1;
        for (int k = 1; k <= 3; k++) expQ.push_back({1'b0, 4'd0, 4'(k)});
        for (int k = 1; k <= 3; k++) begin
            waitTick(20, edges);
            checks++;
            if (edges !== 10)
                begin errors++; $display("[TB] FAIL slow_period[%0d]: got %0d edges expected 10", k, edges); end
            exp = expQ.pop_front();
            checks++;
            if ({full, bcd1, bcd0} !== exp)
                begin errors++; $display("[TB] FAIL slow_digits[%0d]: got %h expected %h", k, {full, bcd1, bcd0}, exp); end
        end
        step(1);
        checks++;
        if (tick !== 1'b0)
            begin errors++; $display("[TB] FAIL tick_width: got %b expected 0", tick); end
    endtask

    task automatic test_quick();
        int edges;
        logic [8:0] exp;
        // Clear and mode change together: clear wins, mode_q still follows.
        clear = 1'b1;
        mode  = 1'b0;
        step(1);
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL quick_clear: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
        clear = 1'b0;
        for (int k = 1; k <= 10; k++) expQ.push_back({1'b0, 4'(k / 10), 4'(k % 10)});
        for (int k = 1; k <= 10; k++) begin
            waitTick(12, edges);
            checks++;
            if (edges !== 4)
                begin errors++; $display("[TB] FAIL quick_period[%0d]: got %0d edges expected 4", k, edges); end
            exp = expQ.pop_front();
            checks++;
            if ({full, bcd1, bcd0} !== exp)
                begin errors++; $display("[TB] FAIL quick_digits[%0d]: got %h expected %h", k, {full, bcd1, bcd0}, exp); end
        end
    endtask

    task automatic test_mode_change();
        int edges;
        logic [8:0] exp;
        mode = 1'b1;
        expQ.push_back({1'b0, 4'd1, 4'd1});
        waitTick(30, edges);
        checks++;
        if (edges !== 11)
            begin errors++; $display("[TB] FAIL to_slow_period: got %0d edges expected 11", edges); end
        exp = expQ.pop_front();
        checks++;
        if ({full, bcd1, bcd0} !== exp)
            begin errors++; $display("[TB] FAIL to_slow_digits: got %h expected %h", {full, bcd1, bcd0}, exp); end
        step(7);
        mode = 1'b0;
        step(1);
        checks++;
        if ({tick, full, bcd1, bcd0} !== {1'b0, 1'b0, 4'd1, 4'd1})
            begin errors++; $display("[TB] FAIL switch_edge: got %b expected %b", {tick, full, bcd1, bcd0}, {2'b00, 4'd1, 4'd1}); end
        expQ.push_back({1'b0, 4'd1, 4'd2});
        waitTick(12, edges);
        checks++;
        if (edges !== 4)
            begin errors++; $display("[TB] FAIL after_switch_period: got %0d edges expected 4", edges); end
        exp = expQ.pop_front();
        checks++;
        if ({full, bcd1, bcd0} !== exp)
            begin errors++; $display("[TB] FAIL after_switch_digits: got %h expected %h", {full, bcd1, bcd0}, exp); end
        // Mode change landing exactly on the tick-due edge must suppress that tick.
        step(3);
        mode = 1'b1;
        step(1);
        checks++;
        if ({tick, bcd1, bcd0} !== {1'b0, 4'd1, 4'd2})
            begin errors++; $display("[TB] FAIL switch_at_limit: got %b expected %b", {tick, bcd1, bcd0}, {1'b0, 4'd1, 4'd2}); end
        waitTick(15, edges);
        checks++;
        if (edges !== 10)
            begin errors++; $display("[TB] FAIL switch_at_limit_period: got %0d edges expected 10", edges); end
    endtask

    task automatic test_clear_collision();
        int edges;
        logic [8:0] exp;
        clear = 1'b1;
        mode  = 1'b0;
        step(1);
        clear = 1'b0;
        for (int k = 1; k <= 42; k++) expQ.push_back({1'b0, 4'(k / 10), 4'(k % 10)});
        for (int k = 1; k <= 42; k++) begin
            waitTick(12, edges);
            exp = expQ.pop_front();
            checks++;
            if (edges !== 4 || {full, bcd1, bcd0} !== exp)
                begin errors++; $display("[TB] FAIL run_to_42[%0d]: got %0d edges %h expected 4 edges %h", k, edges, {full, bcd1, bcd0}, exp); end
        end
        step(3);
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL clear_collision: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
        expQ.push_back({1'b0, 4'd0, 4'd1});
        waitTick(12, edges);
        checks++;
        if (edges !== 4)
            begin errors++; $display("[TB] FAIL post_clear_period: got %0d edges expected 4", edges); end
        exp = expQ.pop_front();
        checks++;
        if ({full, bcd1, bcd0} !== exp)
            begin errors++; $display("[TB] FAIL post_clear_digits: got %h expected %h", {full, bcd1, bcd0}, exp); end
    endtask

    task automatic test_boundary();
        int edges;
        logic [8:0] exp;
        for (int k = 2; k <= 99; k++) begin
`ifdef MODE_RATE_COUNTER_WRAP_EN
            expQ.push_back({1'b0, 4'(k / 10), 4'(k % 10)});
`else
            expQ.push_back({(k == 99), 4'(k / 10), 4'(k % 10)});
`endif
        end
`ifdef MODE_RATE_COUNTER_WRAP_EN
        expQ.push_back({1'b1, 4'd0, 4'd0});
`else
        expQ.push_back({1'b1, 4'd9, 4'd9});
`endif
        for (int k = 2; k <= 100; k++) begin
            waitTick(12, edges);
            exp = expQ.pop_front();
            checks++;
            if (edges !== 4 || {full, bcd1, bcd0} !== exp)
                begin errors++; $display("[TB] FAIL boundary_tick[%0d]: got %0d edges %h expected 4 edges %h", k, edges, {full, bcd1, bcd0}, exp); end
        end
        step(1);
`ifdef MODE_RATE_COUNTER_WRAP_EN
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL wrap_full_pulse: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
`else
        checks++;
        if ({tick, full, bcd1, bcd0} !== {1'b0, 1'b1, 4'd9, 4'd9})
            begin errors++; $display("[TB] FAIL sat_hold: got %b expected %b", {tick, full, bcd1, bcd0}, {2'b01, 4'd9, 4'd9}); end
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL sat_clear: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
`endif
    endtask

    task automatic test_async_reset();
        int edges;
        logic [8:0] exp;
        clear = 1'b1;
        mode  = 1'b0;
        step(1);
        clear = 1'b0;
        for (int k = 1; k <= 57; k++) expQ.push_back({1'b0, 4'(k / 10), 4'(k % 10)});
        for (int k = 1; k <= 57; k++) begin
            waitTick(12, edges);
            exp = expQ.pop_front();
            checks++;
            if (edges !== 4 || {full, bcd1, bcd0} !== exp)
                begin errors++; $display("[TB] FAIL run_to_57[%0d]: got %0d edges %h expected 4 edges %h", k, edges, {full, bcd1, bcd0}, exp); end
        end
        step(2);
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL async_reset: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
        @(posedge clk);
        #1;
        checks++;
        if ({tick, full, bcd1, bcd0} !== 10'b0)
            begin errors++; $display("[TB] FAIL reset_held: got %b expected %b", {tick, full, bcd1, bcd0}, 10'b0); end
        rst = 1'b1;
        // mode_q comes out of reset as slow, so the first edge is a mode change.
        expQ.push_back({1'b0, 4'd0, 4'd1});
        waitTick(20, edges);
        checks++;
        if (edges !== 5)
            begin errors++; $display("[TB] FAIL resume_period: got %0d edges expected 5", edges); end
        exp = expQ.pop_front();
        checks++;
        if ({full, bcd1, bcd0} !== exp)
            begin errors++; $display("[TB] FAIL resume_digits: got %h expected %h", {full, bcd1, bcd0}, exp); end
    endtask

    initial begin
        test_reset();
        test_quick();
        test_mode_change();
        test_clear_collision();
        test_boundary();
        test_async_reset();
        checks++;
        if (expQ.size() !== 0)
            begin errors++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", expQ.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
